dekatron_step_sequencer: RTL and testbench

Sequencer for a multi-digit decimal register built from one-hot dekatron digit counters. Each digit holds 10 one-hot bits and has the inputs Step (active on rising edge), Reverse, Set and In. On request, this block performs one increment, decrement or parallel load. It issues timed Step pulses digit by digit and ripples carry/borrow upward by sampling the digits' one-hot outputs. It sits between the machine's control unit (IP/AP/data counters) and the digit chain.

---
 rtl/dekatron_step_sequencer.sv | 109 ++++++++++
 tb/tb_dekatron_step_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dekatron_step_sequencer.sv
// Step sequencer for a chain of one-hot dekatron digits. It increments or decrements
// the chain with a rippling carry/borrow, or loads all digits in parallel.
module dekatron_step_sequencer #(
  parameter int DIGITS       = 3,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 3
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Request,
  input  logic                  Dec,
  input  logic                  Load,
  input  logic [DIGITS*10-1:0]  LoadValue,
  input  logic [DIGITS*10-1:0]  DigitsIn,
  output logic [DIGITS-1:0]     Step,
  output logic                  Reverse,
  output logic                  Set,
  output logic [DIGITS*10-1:0]  DigitsLoad,
  output logic                  Ready,
  output logic                  Done,
  output logic                  Overflow
);

  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_GAP, S_DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx, idx_n;
  logic            carry, op_dec, op_load;
  logic            pulse_end, gap_end, ripple;
  logic [DIGITS-1:0] top_bit, bot_bit;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      assign top_bit[g] = DigitsIn[10*g+9];
      assign bot_bit[g] = DigitsIn[10*g];
      assign Step[g]    = (state == S_PULSE) && (op_load || idx == IW'(g));
    end
  endgenerate

  assign pulse_end = (cnt == CW'(PULSE_CYCLES - 1));
  assign gap_end   = (cnt == CW'(GAP_CYCLES - 1));
  assign ripple    = !op_load && carry;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      S_IDLE:  if (Request) begin
                 state_n = S_SETUP;
                 idx_n   = '0;
               end
      S_SETUP: state_n = S_PULSE;
      S_PULSE: if (pulse_end) state_n = S_GAP;
      S_GAP:   if (gap_end) begin
                 if (ripple && idx != IW'(DIGITS - 1)) begin
                   state_n = S_PULSE;
                   idx_n   = idx + IW'(1);
                 end else begin
                   state_n = S_DONE;
                 end
               end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      op_dec     <= 1'b0;
      op_load    <= 1'b0;
      DigitsLoad <= '0;
      Overflow   <= 1'b0;
    end else begin
      idx <= idx_n;
      cnt <= (state_n != state || state == S_IDLE) ? '0 : cnt + CW'(1);
      if (state == S_IDLE && Request) begin
        op_dec     <= Dec;
        op_load    <= Load;
        DigitsLoad <= LoadValue;
        Overflow   <= 1'b0;
      end
      // Carry comes from the target digit's pre-step value, sampled as its pulse begins
      if (state_n == S_PULSE && state != S_PULSE)
        carry <= op_dec ? bot_bit[idx_n] : top_bit[idx_n];
      if (state == S_GAP && gap_end && ripple && idx == IW'(DIGITS - 1))
        Overflow <= 1'b1;
    end
  end

  assign Ready   = (state == S_IDLE);
  assign Done    = (state == S_DONE);
  assign Reverse = (state != S_IDLE) && op_dec && !op_load;
  assign Set     = (state != S_IDLE) && op_load;

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Directed bench for dekatron_step_sequencer with three behavioural one-hot digits
// attached. It checks step timing, carry ripple, load, request rejection and mid-op reset.
module tb_dekatron_step_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, request = 1'b0, dec = 1'b0, load = 1'b0;
  logic [29:0] load_value = '0;
  wire  [29:0] digits_in;
  logic [2:0]  step;
  logic        reverse, set_o, ready, done, overflow;
  logic [29:0] digits_load;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dekatron_step_sequencer dut (
    .Clk(clk), .Rst_n(rst_n), .Request(request), .Dec(dec), .Load(load),
    .LoadValue(load_value), .DigitsIn(digits_in), .Step(step), .Reverse(reverse),
    .Set(set_o), .DigitsLoad(digits_load), .Ready(ready), .Done(done), .Overflow(overflow)
  );

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gd
      logic [9:0] v = 10'b1;
      always @(posedge step[g]) begin
        if (set_o)        v <= digits_load[g*10 +: 10];
        else if (reverse) v <= {v[0], v[9:1]};
        else              v <= {v[8:0], v[9]};
      end
      assign digits_in[g*10 +: 10] = v;
    end
  endgenerate

  // Edge monitors; cyc here equals e0+k in the cycle after edge Ek
  int         rise_cnt [3] = '{0, 0, 0};
  int         rise_last[3] = '{0, 0, 0};
  logic [2:0] step_q = '0;
  int         done_cnt = 0, done_cyc = 0;
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++)
      if (step[d] && !step_q[d]) begin
        rise_cnt[d]  <= rise_cnt[d] + 1;
        rise_last[d] <= cyc;
      end
    step_q <= step;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] enc(input int n);
    logic [29:0] r;
    r = '0;
    r[20 + (n / 100) % 10] = 1'b1;
    r[10 + (n / 10) % 10]  = 1'b1;
    r[n % 10]              = 1'b1;
    return r;
  endfunction

  function automatic int dig_val();
    int val, pos, ones;
    val = 0;
    for (int d = 2; d >= 0; d--) begin
      ones = 0; pos = 0;
      for (int b = 0; b < 10; b++)
        if (digits_in[d*10 + b]) begin ones++; pos = b; end
      if (ones != 1) return -1;
      val = val * 10 + pos;
    end
    return val;
  endfunction

  task automatic start_op(input logic d, input logic l, input logic [29:0] lv, output int e0);
    @(negedge clk);
    request = 1'b1; dec = d; load = l; load_value = lv;
    @(posedge clk);
    #1 e0 = cyc;
    request = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk);
      if (done_cnt > base) ok = 1;
    end
    #1;
    if (!ok) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run_op(input string tag, input logic d, input logic l, input int lv,
                        input int k, input int exp_val, input logic exp_ovf);
    int e0, bd, br[3];
    bd = done_cnt;
    for (int i = 0; i < 3; i++) br[i] = rise_cnt[i];
    start_op(d, l, l ? enc(lv) : 30'd0, e0);
    chk({tag, "_set_setup"}, set_o, l);
    chk({tag, "_rev_setup"}, reverse, d & ~l);
    wait_done(tag, bd);
    chk({tag, "_done_cyc"}, done_cyc - e0, 1 + k * 5);
    chk({tag, "_done_cnt"}, done_cnt - bd, 1);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_value"}, dig_val(), exp_val);
    chk({tag, "_ovf"}, overflow, exp_ovf);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_rises%0d", tag, i), rise_cnt[i] - br[i], (l || i < k) ? 1 : 0);
      if (l || i < k)
        chk($sformatf("%s_rise_cyc%0d", tag, i), rise_last[i] - e0, l ? 1 : 1 + i * 5);
    end
  endtask

  initial begin
    int e0, bd, br[3];
    #3;
    chk("rst_step", step, 0);
    chk("rst_rev", reverse, 0);
    chk("rst_set", set_o, 0);
    chk("rst_dload", digits_load, 0);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk) rst_n = 1'b1;

    run_op("inc000", 1'b0, 1'b0, 0,   1, 1,   1'b0);
    run_op("ld472",  1'b0, 1'b1, 472, 1, 472, 1'b0);
    run_op("ld999",  1'b0, 1'b1, 999, 1, 999, 1'b0);
    run_op("inc999", 1'b0, 1'b0, 0,   3, 0,   1'b1);
    run_op("ld100",  1'b0, 1'b1, 100, 1, 100, 1'b0);
    run_op("dec100", 1'b1, 1'b0, 0,   3, 99,  1'b0);

    // Request pulsed during the first GAP of a ripple must be ignored
    bd = done_cnt;
    for (int i = 0; i < 3; i++) br[i] = rise_cnt[i];
    start_op(1'b0, 1'b0, 30'd0, e0);
    repeat (3) @(posedge clk);
    @(negedge clk) request = 1'b1;
    @(negedge clk) request = 1'b0;
    wait_done("gapreq", bd);
    repeat (10) @(posedge clk);
    #1;
    chk("gapreq_done_cyc", done_cyc - e0, 16);
    chk("gapreq_done_cnt", done_cnt - bd, 1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("gapreq_rises%0d", i), rise_cnt[i] - br[i], 1);
    chk("gapreq_value", dig_val(), 100);

    // Reset during the second PULSE of 999+1
    run_op("ld999b", 1'b0, 1'b1, 999, 1, 999, 1'b0);
    bd = done_cnt;
    start_op(1'b0, 1'b0, 30'd0, e0);
    repeat (7) @(posedge clk);
    #2;
    chk("midrst_pre_step", step, 3'b010);
    rst_n = 1'b0;
    #1;
    chk("midrst_step", step, 0);
    chk("midrst_rev", reverse, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_ovf", overflow, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt - bd, 0);
    chk("midrst_value", dig_val(), 900);
    run_op("inc900", 1'b0, 1'b0, 0, 1, 901, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
